// File: rtl/dsp48a1_mac_ctrl.sv
// Drives a single DSP48A1 slice as a signed multiply-accumulate engine:
// clears the slice, streams N operand pairs in, drains the pipe, returns P.
module dsp48a1_mac_ctrl #(
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_ceopmode,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);
    // One tag per register stage between the A1/B1 capture and P.
    localparam int VW = PIPE_LAT - 1;
    localparam logic [7:0] OPMODE_MAC = 8'h09;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]     v_q, v_d;
    logic              busy_q, busy_d;
    logic              s_ready_q, s_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              dsp_rst_q, dsp_rst_d;
    logic              accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = s_valid && s_ready_q;
        v_d     = {v_q[VW-2:0], accept};
        case (state_q)
            S_IDLE: if (start) begin
                cnt_d   = len;
                state_d = S_CLR;
            end
            S_CLR: state_d = (cnt_q != '0) ? S_FEED : S_DONE;
            S_FEED: if (accept) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
            end
            // Looking at the next tag value lets DONE coincide with the P update landing.
            S_DRAIN: if (v_d == '0) state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        s_ready_d   = (state_d == S_FEED);
        res_valid_d = (state_d == S_DONE);
        dsp_rst_d   = (state_d == S_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            v_q         <= '0;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            dsp_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            v_q         <= v_d;
            busy_q      <= busy_d;
            s_ready_q   <= s_ready_d;
            res_valid_q <= res_valid_d;
            dsp_rst_q   <= dsp_rst_d;
        end
    end

    assign busy         = busy_q;
    assign s_ready      = s_ready_q;
    assign res_valid    = res_valid_q;
    assign res_data     = dsp_p;
    assign dsp_a        = accept ? s_a : '0;
    assign dsp_b        = accept ? s_b : '0;
    assign dsp_cea      = accept;
    assign dsp_ceb      = accept;
    assign dsp_cem      = v_q[0];
    assign dsp_cep      = v_q[VW-1];
    assign dsp_opmode   = OPMODE_MAC;
    assign dsp_ceopmode = 1'b1;
    // RST reaches the slice directly; the held flop covers the cycle after release.
    assign dsp_rst      = RST | dsp_rst_q;

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Directed bench for dsp48a1_mac_ctrl with a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registers, sync reset) closing the loop on dsp_p.
module tb_dsp48a1_mac_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [9:0]  len;
    logic        busy, s_valid, s_ready, res_valid, res_ready;
    logic [17:0] s_a, s_b, dsp_a, dsp_b;
    logic [47:0] res_data, dsp_p;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dsp48a1_mac_ctrl #(.LEN_W(10), .PIPE_LAT(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
        .dsp_ceopmode(dsp_ceopmode), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
    );

    // Slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, sync reset.
    logic signed [17:0] a1, b1;
    logic signed [35:0] m;
    logic [7:0]         opm;
    logic [47:0]        xmux, zmux;
    always_comb begin
        xmux = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
        zmux = (opm[3:2] == 2'b10) ? dsp_p : 48'd0;
    end
    always @(posedge CLK) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m <= '0; dsp_p <= '0; opm <= '0;
        end else begin
            if (dsp_cea) a1 <= dsp_a;
            if (dsp_ceb) b1 <= dsp_b;
            if (dsp_cem) m <= a1 * b1;
            if (dsp_cep) dsp_p <= opm[7] ? zmux - xmux : zmux + xmux;
            if (dsp_ceopmode) opm <= dsp_opmode;
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Pulse start in IDLE, check CLR, and step into the next state.
    task automatic start_job(input logic [9:0] l);
        start = 1'b1; len = l;
        cyc();
        start = 1'b0;
        #1;
        chk("clr_busy", 48'(busy), 48'd1);
        chk("clr_rst", 48'(dsp_rst), 48'd1);
        chk("clr_sready", 48'(s_ready), 48'd0);
        cyc();
    endtask

    task automatic feed(input logic [17:0] a, input logic [17:0] b);
        s_valid = 1'b1; s_a = a; s_b = b;
        #1;
        chk("feed_sready", 48'(s_ready), 48'd1);
        chk("feed_cea", 48'({dsp_cea, dsp_ceb}), 48'd3);
        chk("feed_a", 48'(dsp_a), 48'(a));
        chk("feed_b", 48'(dsp_b), 48'(b));
        cyc();
        s_valid = 1'b0;
    endtask

    // Bounded wait for res_valid; n is the number of cycles it took.
    task automatic wait_res(input int n_exp, input logic [47:0] d_exp, input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"}, 48'(n), 48'(n_exp));
        chk({tag, "_data"}, res_data, d_exp);
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        cyc();
        chk({tag, "_idle_busy"}, 48'(busy), 48'd0);
        chk({tag, "_idle_rv"}, 48'(res_valid), 48'd0);
    endtask

    initial begin
        int seen;
        RST = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0;
        s_a = '0; s_b = '0; res_ready = 1'b0;

        // Reset with noise on the stream inputs
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_a = 18'($urandom); s_b = 18'($urandom);
            cyc();
        end
        #1;
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_sready", 48'(s_ready), 48'd0);
        chk("rst_rvalid", 48'(res_valid), 48'd0);
        chk("rst_dsprst", 48'(dsp_rst), 48'd1);
        chk("rst_a", 48'(dsp_a), 48'd0);
        chk("rst_ces", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep}), 48'd0);
        chk("rst_opmode", 48'(dsp_opmode), 48'h09);
        chk("rst_ceopm", 48'(dsp_ceopmode), 48'd1);
        s_valid = 1'b0; RST = 1'b0;
        #1;
        chk("rst_hold", 48'(dsp_rst), 48'd1);
        cyc();
        chk("rst_released", 48'(dsp_rst), 48'd0);
        chk("rst_p", dsp_p, 48'd0);

        // Basic: 20*10 + 5*6 + 3*7 = 251
        res_ready = 1'b1;
        start_job(10'd3);
        feed(18'd20, 18'd10);
        feed(18'd5, 18'd6);
        feed(18'd3, 18'd7);
        chk("basic_drain_sready", 48'(s_ready), 48'd0);
        chk("basic_drain_rv", 48'(res_valid), 48'd0);
        wait_res(2, 48'h0000_0000_00FB, "basic");
        release_res("basic");

        // Signed with bubbles: -4*5 + 2*-3 = -26
        start_job(10'd2);
        feed(-18'sd4, 18'd5);
        #1;
        chk("bub1_cea", 48'(dsp_cea), 48'd0);
        chk("bub1_cemp", 48'({dsp_cem, dsp_cep}), 48'b10);
        cyc();
        chk("bub2_cemp", 48'({dsp_cem, dsp_cep}), 48'b01);
        cyc();
        chk("bub3_cemp", 48'({dsp_cem, dsp_cep}), 48'b00);
        cyc();
        feed(18'sd2, -18'sd3);
        wait_res(2, 48'hFFFF_FFFF_FFE6, "signed");
        release_res("signed");

        // Backpressure: result held, start in DONE ignored
        res_ready = 1'b0;
        start_job(10'd3);
        feed(18'd20, 18'd10);
        feed(18'd5, 18'd6);
        feed(18'd3, 18'd7);
        wait_res(2, 48'h0000_0000_00FB, "bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; len = 10'd1; end
            #1;
            chk("bp_rv", 48'(res_valid), 48'd1);
            chk("bp_data", res_data, 48'h0000_0000_00FB);
            chk("bp_sready", 48'(s_ready), 48'd0);
            cyc();
            start = 1'b0;
        end
        chk("bp_busy", 48'(busy), 48'd1);
        release_res("bp");
        start_job(10'd1);
        feed(18'd7, 18'd7);
        wait_res(2, 48'h0000_0000_0031, "after_bp");
        release_res("after_bp");

        // len=0: CLR straight to DONE with a cleared P
        start_job(10'd0);
        chk("len0_sready", 48'(s_ready), 48'd0);
        wait_res(0, 48'd0, "len0");
        release_res("len0");

        // Reset mid-job
        start_job(10'd4);
        feed(18'd1, 18'd1);
        feed(18'd2, 18'd2);
        RST = 1'b1;
        cyc();
        chk("mid_busy", 48'(busy), 48'd0);
        chk("mid_rv", 48'(res_valid), 48'd0);
        chk("mid_sready", 48'(s_ready), 48'd0);
        RST = 1'b0;
        #1;
        chk("mid_hold", 48'(dsp_rst), 48'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (res_valid === 1'b1) seen++;
        end
        chk("mid_no_result", 48'(seen), 48'd0);
        start_job(10'd1);
        feed(18'd9, 18'd9);
        wait_res(2, 48'h0000_0000_0051, "after_mid");
        release_res("after_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
